multiplier_state_machine: RTL and testbench
===========================================

Name: multiplier_state_machine

Overview:
- Control unit for the 4x4 sequential shift-add multiplier. It is a Moore state register (`state_machine` part) plus a purely combinational decoder from present state to datapath controls (`signal_assigner` part).
- It sequences load, add and shift steps four times, then raises `ready`.
- It drives the datapath mux selects (`s0`, `s1`, `s2`), the register clear (`sig_rst`) and the register loads (`ld1`, `ld2`).

Parameters:
- None. State encoding is 3 bits and the iteration count is fixed at 4.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request to begin a multiplication; level-sampled
- ps  output  3  present state, exported for debug and display
- s0  output  1  datapath mux select: partial-product/add path
- s1  output  1  datapath mux select: shift path
- s2  output  1  datapath mux select: result-to-output path
- sig_rst  output  1  synchronous clear of product/accumulator registers
- ld1  output  1  load operand registers
- ld2  output  1  load product/accumulator register
- ready  output  1  idle or result valid

Behaviour:
- One clock domain, `clk`. Reset is synchronous and active-high.
- `rst` has priority over everything: on the clock edge it sets `ps` to 0 and the internal 2-bit iteration counter `v` to 0. This holds regardless of `start`, including X on `start`.
- A reset asserted mid-operation aborts the multiplication at the next edge.
- The counter is named `v` and must be visible at hierarchy level `v` for benches.
- Outputs are a function of `ps` only (Moore), with no registered delay.
- States and their outputs (all outputs not listed are 0):
  - 0 IDLE: `ready`=1.
  - 1 LOAD: `sig_rst`=1, `ld1`=1.
  - 2 ADD: `s0`=1, `ld2`=1.
  - 3 SHIFT: `s1`=1, `ld2`=1.
  - 4 DONE: `s2`=1, `ready`=1.
  - 5, 6, 7 (illegal): all outputs 0.
- Transitions, evaluated on the rising edge when `rst`=0:
  - IDLE: `start`=1 -> LOAD; otherwise stay.
  - LOAD: -> ADD unconditionally; `v` <= 0.
  - ADD: -> SHIFT unconditionally.
  - SHIFT: `v` <= `v`+1. If `v`==3 before the increment -> DONE (`v` wraps to 0); otherwise -> ADD.
  - DONE: `start`=0 -> IDLE; `start`=1 -> stay. A held `start` does not retrigger.
  - Illegal states -> IDLE next edge; `v` <= 0.
- `v` changes only in LOAD, SHIFT, illegal states and reset; it holds elsewhere.
- Latency: `start` sampled high in IDLE at edge N gives LOAD at N, ADD at N+1, and ADD/SHIFT pairs through N+8. DONE (`ready`=1) is entered at edge N+9. `ready` is low for exactly 9 cycles.
- `start` is ignored in LOAD, ADD and SHIFT.
- `start` must not be sampled while `rst`=1.
- The output decoder must be fully combinational with a default assignment, so no latches are inferred.

Test Plan:
- Reset: `rst`=1 for 12 cycles with `start`=X, then 0 -> `ps`=0, `v`=0, `ready`=1, all other outputs 0 throughout.
- Normal run: `rst`=0, `start`=1 for one cycle then 0 -> `ps` sequence 0,1,2,3,2,3,2,3,2,3,4,0.
  - `ld1`/`sig_rst` high only in state 1.
  - `ld2` high in states 2 and 3.
  - `ready` low for exactly 9 cycles.
- Held start: `start`=1 continuously -> reaches `ps`=4 and stays with `ready`=1 and `s2`=1. Dropping `start` -> `ps`=0 next edge.
- Counter: during the normal run `v` reads 0,0,1,1,2,2,3,3 across ADD/SHIFT, then 0 in DONE.
- Reset mid-operation: `rst`=1 while `ps`=3 -> next edge `ps`=0, `v`=0, `ready`=1.
- Illegal state (forced `ps`=6) -> all outputs 0, `ps`=0 next edge.

Source files
------------

// File: rtl/multiplier_state_machine.sv
// Control FSM for the 4x4 shift-add multiplier: LOAD, then four ADD/SHIFT pairs, then DONE.
// Moore outputs decoded from ps; 9 busy cycles between start and ready. No backpressure.
`timescale 1ns/1ps
module multiplier_state_machine (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] ps,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       sig_rst,
    output logic       ld1,
    output logic       ld2,
    output logic       ready
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0] r_ps;
    logic [2:0] w_ns;
    logic [1:0] v;
    logic [1:0] w_v_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps <= ST_IDLE;
            v    <= 2'd0;
        end else begin
            r_ps <= w_ns;
            v    <= w_v_nxt;
        end
    end

    always_comb begin
        w_ns    = ST_IDLE;
        w_v_nxt = v;
        case (r_ps)
            ST_IDLE:  w_ns = start ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                w_ns    = ST_ADD;
                w_v_nxt = 2'd0;
            end
            ST_ADD:   w_ns = ST_SHIFT;
            ST_SHIFT: begin
                // v wraps to 0 on the fourth shift, leaving it clean for the next run
                w_v_nxt = v + 2'd1;
                w_ns    = (v == 2'd3) ? ST_DONE : ST_ADD;
            end
            ST_DONE:  w_ns = start ? ST_DONE : ST_IDLE;
            default: begin
                w_ns    = ST_IDLE;
                w_v_nxt = 2'd0;
            end
        endcase
    end

    always_comb begin
        s0      = 1'b0;
        s1      = 1'b0;
        s2      = 1'b0;
        sig_rst = 1'b0;
        ld1     = 1'b0;
        ld2     = 1'b0;
        ready   = 1'b0;
        case (r_ps)
            ST_IDLE:  ready = 1'b1;
            ST_LOAD: begin
                sig_rst = 1'b1;
                ld1     = 1'b1;
            end
            ST_ADD: begin
                s0  = 1'b1;
                ld2 = 1'b1;
            end
            ST_SHIFT: begin
                s1  = 1'b1;
                ld2 = 1'b1;
            end
            ST_DONE: begin
                s2    = 1'b1;
                ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign ps = r_ps;

endmodule

// File: tb/tb_multiplier_state_machine.sv
// Directed and random bench for multiplier_state_machine against a cycle-count reference model.
`timescale 1ns/1ps
module tb_multiplier_state_machine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] ps;
    logic       s0, s1, s2, sig_rst, ld1, ld2, ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 busy (m_k = cycles since start accepted), 2 done
    int m_mode = 0;
    int m_k    = 0;

    multiplier_state_machine dut (
        .clk(clk), .rst(rst), .start(start), .ps(ps),
        .s0(s0), .s1(s1), .s2(s2), .sig_rst(sig_rst),
        .ld1(ld1), .ld2(ld2), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic s);
        if (r) begin
            m_mode = 0;
            m_k    = 0;
        end else if (m_mode == 0) begin
            if (s === 1'b1) begin
                m_mode = 1;
                m_k    = 0;
            end
        end else if (m_mode == 1) begin
            if (m_k == 8) m_mode = 2;
            else          m_k    = m_k + 1;
        end else begin
            if (s !== 1'b1) m_mode = 0;
        end
    endtask

    // Expected {ps, s0, s1, s2, sig_rst, ld1, ld2, ready}
    function automatic logic [9:0] exp_outs();
        logic [9:0] e;
        if (m_mode == 0)      e = {3'd0, 7'b0000001};
        else if (m_mode == 2) e = {3'd4, 7'b0010001};
        else if (m_k == 0)    e = {3'd1, 7'b0001100};
        else if (m_k % 2 == 1) e = {3'd2, 7'b1000010};
        else                  e = {3'd3, 7'b0100010};
        return e;
    endfunction

    function automatic logic [1:0] exp_v();
        if (m_mode == 1 && m_k > 0) return 2'((m_k - 1) / 2);
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_outs"}, {ps, s0, s1, s2, sig_rst, ld1, ld2, ready}, exp_outs());
        chk({tag, "_v"}, {8'd0, dut.v}, {8'd0, exp_v()});
    endtask

    task automatic cyc(input logic r, input logic s, input string tag);
        @(negedge clk);
        rst   = r;
        start = s;
        @(posedge clk);
        model_step(r, s);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [2:0] seq [11];
        int ready_low;
        seq = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd0};
        rst   = 1'b1;
        start = 1'bx;

        // Reset with start unknown
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'bx, "reset");
        chk("reset_ready", {9'd0, ready}, 10'd1);
        cyc(1'b0, 1'b0, "post_reset");

        // Normal run: one-cycle start pulse
        ready_low = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, (i == 0) ? 1'b1 : 1'b0, "normal");
            chk("normal_ps_seq", {7'd0, ps}, {7'd0, seq[i]});
            if (ready == 1'b0) ready_low++;
        end
        chk("ready_low_cycles", 10'(ready_low), 10'd9);

        // Held start parks in DONE, release returns to IDLE
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, "held");
        chk("held_done", {ps, s2, ready}, {3'd4, 1'b1, 1'b1});
        cyc(1'b0, 1'b0, "held_release");
        chk("held_release_ps", {7'd0, ps}, 10'd0);

        // Reset while in SHIFT
        cyc(1'b0, 1'b1, "abort_go");
        cyc(1'b0, 1'b0, "abort_add");
        cyc(1'b0, 1'b0, "abort_shift");
        chk("abort_in_shift", {7'd0, ps}, 10'd3);
        cyc(1'b1, 1'b0, "abort_rst");
        chk("abort_result", {ps, dut.v, ready}, {3'd0, 2'd0, 1'b1});

        // Illegal state: outputs all low, recovers to IDLE
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        force dut.r_ps = 3'd6;
        #1;
        chk("illegal_outs", {ps, s0, s1, s2, sig_rst, ld1, ld2, ready}, {3'd6, 7'b0});
        release dut.r_ps;
        @(posedge clk);
        #1;
        chk("illegal_recover", {ps, dut.v, ready}, {3'd0, 2'd0, 1'b1});
        m_mode = 0;
        m_k    = 0;

        // Random start/reset traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 25) == 0, 1'($urandom % 2), "random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
